pipeline_hazard_ctrl: RTL

- Central controller for the 3-stage RV32I pipeline (Fetch, Decode/Execute, Memory/Writeback).
- Sequences the Fetch-to-DE and DE-to-MW pipeline registers through stall, flush/bubble, operand forwarding and PC-redirect decisions.
- Freezes the pipeline while the data memory handshakes a load or store. Raises a bus error after a programmable timeout.

---
 rtl/pipe_ctrl_pkg.sv | 50 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/hazard_detect.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 3-stage pipeline hazard controller.
// Holds the controller state encoding, the pc_sel and writeback-source codes,
// the RV32I opcodes the controller decodes, and a source-register usage helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    LOAD_STALL = 2'd2,
    REDIRECT   = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_MEPC   = 2'd2;
  localparam logic [1:0] PC_MTVEC  = 2'd3;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_LOAD = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_CSR  = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Returns {uses_rs2, uses_rs1}. CSR register forms (csrrw/csrrs/csrrc) read
  // rs1; the immediate forms and ecall/ebreak/mret (funct3 == 0) read nothing.
  function automatic logic [1:0] src_use(input logic [6:0] opcode,
                                         input logic [2:0] funct3);
    logic [1:0] u;
    u = 2'b00;
    case (opcode)
      OP_REG, OP_STORE, OP_BRANCH: u = 2'b11;
      OP_IMM, OP_LOAD, OP_JALR:    u = 2'b01;
      OP_SYSTEM:                   u = {1'b0, (funct3 != 3'b000) && !funct3[2]};
      OP_LUI, OP_AUIPC, OP_JAL:    u = 2'b00;
      default:                     u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline datapath.
// master: the controller (reads instruction/handshake status, drives controls).
// slave:  the datapath (drives status, consumes controls).
interface pipeline_hazard_ctrl_if;
  logic [31:0] de_instr;
  logic [31:0] mw_instr;
  logic        mw_rfwrite;
  logic [1:0]  mw_wdata_sel;
  logic        br_taken;
  logic        mw_is_mret;
  logic        trap_req;
  logic        dmem_ack;

  logic        fwd_a;
  logic        fwd_b;
  logic        stall_f;
  logic        stall_mw;
  logic        flush_f;
  logic        bubble_de;
  logic [1:0]  pc_sel;
  logic        dmem_req;
  logic        bus_err;
  logic [1:0]  state_o;

  modport master (
    input  de_instr, mw_instr, mw_rfwrite, mw_wdata_sel, br_taken,
           mw_is_mret, trap_req, dmem_ack,
    output fwd_a, fwd_b, stall_f, stall_mw, flush_f, bubble_de, pc_sel,
           dmem_req, bus_err, state_o
  );

  modport slave (
    output de_instr, mw_instr, mw_rfwrite, mw_wdata_sel, br_taken,
           mw_is_mret, trap_req, dmem_ack,
    input  fwd_a, fwd_b, stall_f, stall_mw, flush_f, bubble_de, pc_sel,
           dmem_req, bus_err, state_o
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational register-dependency compare between the DE and MW stages.
// Inputs : de_instr, mw_instr, mw_rfwrite, mw_wdata_sel
// Outputs: fwd_a/fwd_b (MW result usable for rs1/rs2), load_use (DE needs
//          load data still in MW), mw_mem (MW instruction is a load or store)
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] de_instr,
  input  logic [31:0] mw_instr,
  input  logic        mw_rfwrite,
  input  logic [1:0]  mw_wdata_sel,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        load_use,
  output logic        mw_mem
);

  logic [4:0] rs1, rs2, rd;
  logic [1:0] use_rs;
  logic       rd_live, hit_a, hit_b, fwd_src;
  logic       unused_bits;

  assign rs1    = de_instr[19:15];
  assign rs2    = de_instr[24:20];
  assign rd     = mw_instr[11:7];
  assign use_rs = src_use(de_instr[6:0], de_instr[14:12]);

  // x0 is never a real producer.
  assign rd_live = mw_rfwrite && (rd != 5'd0);
  assign hit_a   = rd_live && use_rs[0] && (rs1 == rd);
  assign hit_b   = rd_live && use_rs[1] && (rs2 == rd);

  // Load data arrives too late in MW to be forwarded; it forces a stall instead.
  assign fwd_src  = (mw_wdata_sel == WD_ALU) || (mw_wdata_sel == WD_PC4) ||
                    (mw_wdata_sel == WD_CSR);
  assign fwd_a    = hit_a && fwd_src;
  assign fwd_b    = hit_b && fwd_src;
  assign load_use = (mw_wdata_sel == WD_LOAD) && (hit_a || hit_b);

  assign mw_mem = (mw_instr[6:0] == OP_LOAD) || (mw_instr[6:0] == OP_STORE);

  assign unused_bits = ^{de_instr[31:25], de_instr[11:7], mw_instr[31:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward/redirect controller for the 3-stage RV32I pipeline.
// Ports: clk, reset (async, active-high), bus (pipeline_hazard_ctrl_if.master)
// carrying DE/MW instruction status, branch/trap/mret events, the data memory
// ack, and the stall, flush, bubble, forward, pc_sel, dmem_req, bus_err and
// debug state outputs.
//
// state      | meaning
// RUN        | normal flow, all hazards evaluated
// MEM_WAIT   | data memory access pending, pipeline frozen
// LOAD_STALL | one bubble cycle after a load-use stall
// REDIRECT   | one cycle after trap/mret, wrong-path fetch dropped
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
)(
  input logic                    clk,
  input logic                    reset,
  pipeline_hazard_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be at least 2");
  end
  // The datapath injects NOP_INSTR on flush; it must be an OP-IMM encoding
  // so the hazard compare treats it as writing nothing useful.
  if (NOP_INSTR[6:0] != OP_IMM) begin : g_bad_nop
    $error("NOP_INSTR must be an OP-IMM encoding");
  end

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fwd_a, fwd_b, load_use, mw_mem;
  logic stall_f, stall_mw, flush_f, bubble_de, dmem_req, bus_err;
  logic [1:0] pc_sel;

  hazard_detect u_hazard_detect (
    .de_instr     (bus.de_instr),
    .mw_instr     (bus.mw_instr),
    .mw_rfwrite   (bus.mw_rfwrite),
    .mw_wdata_sel (bus.mw_wdata_sel),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .load_use     (load_use),
    .mw_mem       (mw_mem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_f   = 1'b0;
    stall_mw  = 1'b0;
    flush_f   = 1'b0;
    bubble_de = 1'b0;
    dmem_req  = 1'b0;
    bus_err   = 1'b0;
    pc_sel    = PC_PLUS4;
    unique case (state_q)
      RUN: begin
        if (bus.trap_req) begin
          pc_sel = PC_MTVEC; flush_f = 1'b1; bubble_de = 1'b1; state_d = REDIRECT;
        end else if (bus.mw_is_mret) begin
          pc_sel = PC_MEPC; flush_f = 1'b1; bubble_de = 1'b1; state_d = REDIRECT;
        end else if (mw_mem && !bus.dmem_ack) begin
          dmem_req = 1'b1; stall_f = 1'b1; stall_mw = 1'b1;
          state_d  = MEM_WAIT; cnt_d = '0;
        end else begin
          // Zero-wait access completes alongside the normal hazard checks.
          dmem_req = mw_mem;
          if (load_use) begin
            stall_f = 1'b1; bubble_de = 1'b1; state_d = LOAD_STALL;
          end else if (bus.br_taken) begin
            pc_sel = PC_BRANCH; flush_f = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        // trap_req is not looked at here; it is taken in RUN after the exit.
        dmem_req = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (bus.dmem_ack) begin
          // The ack cycle behaves like a zero-wait RUN cycle.
          if (load_use) begin
            stall_f = 1'b1; bubble_de = 1'b1; state_d = LOAD_STALL;
          end else begin
            state_d = RUN;
            if (bus.br_taken) begin
              pc_sel = PC_BRANCH; flush_f = 1'b1;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the access: release the stalls so the pipeline moves on.
          bus_err = 1'b1; state_d = RUN;
        end else begin
          stall_f = 1'b1; stall_mw = 1'b1;
        end
      end
      LOAD_STALL: begin
        state_d = RUN;
      end
      REDIRECT: begin
        flush_f = 1'b1; state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held so a pending access drops at once.
  assign bus.fwd_a     = fwd_a & ~reset;
  assign bus.fwd_b     = fwd_b & ~reset;
  assign bus.stall_f   = stall_f & ~reset;
  assign bus.stall_mw  = stall_mw & ~reset;
  assign bus.flush_f   = flush_f & ~reset;
  assign bus.bubble_de = bubble_de & ~reset;
  assign bus.dmem_req  = dmem_req & ~reset;
  assign bus.bus_err   = bus_err & ~reset;
  assign bus.pc_sel    = reset ? PC_PLUS4 : pc_sel;
  assign bus.state_o   = state_q;

endmodule
